// File: rtl/nibble_add_seq_pkg.sv
// ----------------------------------------------------------------------------
// nibble_add_seq_pkg
// Shared definitions for the nibble-serial adder sequencer:
//   - state_t      : sequencer states (IDLE / RUN / DONE)
//   - NIBBLE       : width of the shared adder slice
//   - widthLegal() : operand widths must be a whole number of nibbles and at
//                    least two nibbles wide
// No ports; imported by the interface, the slice and the top.
// ----------------------------------------------------------------------------
package nibble_add_seq_pkg;

    localparam int NIBBLE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // An operand width is usable only if it splits into whole nibbles and
    // needs at least two passes through the slice.
    function automatic bit widthLegal(input int width);
        return ((width % NIBBLE) == 0) && (width >= 2 * NIBBLE);
    endfunction

endpackage

// File: rtl/nibble_add_seq_if.sv
// ----------------------------------------------------------------------------
// nibble_add_seq_if
// Request/response bundle between a requesting datapath (master) and the
// nibble_add_seq sequencer (slave).
//   start : request a new addition (master -> slave)
//   a, b  : WIDTH-bit operands     (master -> slave)
//   cin   : carry-in               (master -> slave)
//   busy  : nibbles being processed (slave -> master)
//   done  : one-cycle completion pulse (slave -> master)
//   sum   : WIDTH-bit result, held until the next completion (slave -> master)
//   cout  : final carry-out, held with sum (slave -> master)
// ----------------------------------------------------------------------------
interface nibble_add_seq_if #(
    parameter int WIDTH = 16
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );

endinterface

// File: rtl/nibble_add_seq_adder_4bit.sv
// ----------------------------------------------------------------------------
// adder_4bit
// The existing purely combinational 4-bit ripple adder slice that the
// sequencer time-shares across all nibbles of a wide addition.
//   a, b : nibble operands
//   cin  : carry into the nibble
//   sum  : nibble sum
//   cout : carry out of the nibble
// ----------------------------------------------------------------------------
module adder_4bit
    import nibble_add_seq_pkg::*;
(
    input  logic [NIBBLE-1:0] a,
    input  logic [NIBBLE-1:0] b,
    input  logic              cin,
    output logic [NIBBLE-1:0] sum,
    output logic              cout
);

    logic [NIBBLE:0] w_total;

    // Widen by one bit so the carry out of the nibble falls into the MSB.
    assign w_total = {1'b0, a} + {1'b0, b} + {{NIBBLE{1'b0}}, cin};
    assign sum     = w_total[NIBBLE-1:0];
    assign cout    = w_total[NIBBLE];

endmodule

// File: rtl/nibble_add_seq.sv
// ----------------------------------------------------------------------------
// nibble_add_seq
// Adds two WIDTH-bit operands through a single shared 4-bit adder slice, one
// nibble per clock, least-significant nibble first, carrying between nibbles
// in a register. A start/busy/done handshake frames each addition; the
// WIDTH-bit sum and carry-out are held until the next completion.
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   bus : slave side of nibble_add_seq_if (start, a, b, cin in;
//         busy, done, sum, cout out)
// ----------------------------------------------------------------------------
module nibble_add_seq
    import nibble_add_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    nibble_add_seq_if.slave      bus
);

    localparam int N     = WIDTH / NIBBLE;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    // Refuse to elaborate with an operand width the slice cannot tile.
    if (!widthLegal(WIDTH)) begin : gWidthCheck
        $error("nibble_add_seq: WIDTH must be a multiple of 4 and at least 8");
    end

    state_t            r_state;
    state_t            w_nextState;
    logic [IDX_W-1:0]  r_idx;
    logic              r_carry;
    logic [WIDTH-1:0]  r_opA;
    logic [WIDTH-1:0]  r_opB;
    logic [WIDTH-1:0]  r_stage;
    logic [WIDTH-1:0]  r_sum;
    logic              r_cout;

    logic              w_accept;
    logic              w_lastNibble;
    logic [NIBBLE-1:0] w_sliceA;
    logic [NIBBLE-1:0] w_sliceB;
    logic [NIBBLE-1:0] w_sliceSum;
    logic              w_sliceCout;
    logic [WIDTH-1:0]  w_stageNext;

    // A request is only taken when no addition is in flight; the done cycle
    // counts as free so back-to-back requests lose no extra cycle.
    assign w_accept     = bus.start && ((r_state == IDLE) || (r_state == DONE));
    assign w_lastNibble = (r_idx == LAST_IDX);

    // Handshake outputs decode straight from the state register, so busy and
    // done are glitch-free and can never be high together.
    assign bus.busy = (r_state == RUN);
    assign bus.done = (r_state == DONE);
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;

    // Nibble mux: present the current nibble of each latched operand to the
    // shared slice, together with the carry from the previous nibble.
    always_comb begin
        w_sliceA = r_opA[r_idx*NIBBLE +: NIBBLE];
        w_sliceB = r_opB[r_idx*NIBBLE +: NIBBLE];
    end

    adder_4bit u_slice (
        .a    (w_sliceA),
        .b    (w_sliceB),
        .cin  (r_carry),
        .sum  (w_sliceSum),
        .cout (w_sliceCout)
    );

    // Merge the freshly computed nibble into the staging word. On the final
    // nibble this merged word is the complete result that gets published.
    always_comb begin
        w_stageNext = r_stage;
        w_stageNext[r_idx*NIBBLE +: NIBBLE] = w_sliceSum;
    end

    // State register. Reset abandons any in-flight addition outright.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. RUN ignores start entirely; DONE behaves like IDLE
    // for acceptance but lasts exactly one cycle.
    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                if (w_lastNibble) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                if (w_accept) begin
                    w_nextState = RUN;
                end else begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Datapath. Operands are copied once on acceptance so later changes on
    // the bus have no effect. Intermediate nibbles go to r_stage only; the
    // visible sum/cout change solely when the last nibble completes. The
    // index returns to zero after the last nibble rather than wrapping past
    // N-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_opA   <= '0;
            r_opB   <= '0;
            r_stage <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_opA   <= bus.a;
            r_opB   <= bus.b;
            r_carry <= bus.cin;
            r_idx   <= '0;
            r_stage <= '0;
        end else if (r_state == RUN) begin
            r_stage <= w_stageNext;
            r_carry <= w_sliceCout;
            if (w_lastNibble) begin
                r_idx  <= '0;
                r_sum  <= w_stageNext;
                r_cout <= w_sliceCout;
            end else begin
                r_idx  <= r_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nibble_add_seq.sv
// ----------------------------------------------------------------------------
// tb_nibble_add_seq
// Self-checking bench for nibble_add_seq at WIDTH=16 (N=4 nibbles). Drives
// directed additions with hand-computed results, start-during-RUN, start
// held high, asynchronous reset mid-addition, and a sweep of random operands
// checked against plain integer addition.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_nibble_add_seq;

    localparam int WIDTH = 16;
    localparam int N     = WIDTH / 4;

    logic clk;
    logic rst;

    int checkCount;
    int errorCount;

    nibble_add_seq_if #(.WIDTH(WIDTH)) bus ();

    nibble_add_seq #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Issue one request at the next falling edge, release start after the
    // accepting edge, then watch a bounded window of cycles. Sample j is
    // taken 1ns after the j-th edge following the accepting edge; the done
    // pulse is required at sample j=N (the (N+1)-th cycle counting the
    // accepting cycle as the first).
    task automatic applyStimulus(input string tag, input logic [15:0] opA,
                                 input logic [15:0] opB, input logic opCin,
                                 input logic [15:0] expSum, input logic expCout);
        int busyCnt;
        int doneCnt;
        int doneAt;
        int overlap;
        logic [15:0] gotSum;
        logic gotCout;
        busyCnt = 0;
        doneCnt = 0;
        doneAt  = -1;
        overlap = 0;
        gotSum  = '0;
        gotCout = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = opA;
        bus.b     = opB;
        bus.cin   = opCin;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int j = 0; j < N + 4; j++) begin
            if (j > 0) begin
                @(posedge clk);
                #1;
            end
            if (bus.busy && bus.done) overlap++;
            if (bus.busy) busyCnt++;
            if (bus.done) begin
                doneCnt++;
                if (doneAt < 0) begin
                    doneAt  = j;
                    gotSum  = bus.sum;
                    gotCout = bus.cout;
                end
            end
        end
        checkOutput({tag, " sum"},      32'(gotSum),  32'(expSum));
        checkOutput({tag, " cout"},     32'(gotCout), 32'(expCout));
        checkOutput({tag, " latency"},  32'(doneAt),  32'(N));
        checkOutput({tag, " busyCyc"},  32'(busyCnt), 32'(N));
        checkOutput({tag, " donePulse"}, 32'(doneCnt), 32'd1);
        checkOutput({tag, " overlap"},  32'(overlap), 32'd0);
    endtask

    initial begin
        int k;
        int overlap;
        int doneCnt;
        logic [16:0] total;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;

        checkCount = 0;
        errorCount = 0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
        bus.cin    = 1'b0;

        // Reset state.
        #3;
        checkOutput("reset busy", 32'(bus.busy), 32'd0);
        checkOutput("reset done", 32'(bus.done), 32'd0);
        checkOutput("reset sum",  32'(bus.sum),  32'd0);
        checkOutput("reset cout", 32'(bus.cout), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        $display("[TB] reset released");

        // First request right after reset release; carry into nibble 2.
        applyStimulus("carry8", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);
        // Carry-in ripples through every nibble.
        applyStimulus("rippleAll", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
        applyStimulus("mixed", 16'hA5C3, 16'h5A3C, 1'b1, 16'h0000, 1'b1);
        applyStimulus("noCarry", 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0);

        // Start held high: re-accepted in every done cycle, one result per
        // N+1 cycles.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h8000;
        bus.b     = 16'h8000;
        bus.cin   = 1'b0;
        @(posedge clk);
        #1;
        k = 0;
        overlap = 0;
        for (int j = 0; j <= 3 * N + 2; j++) begin
            if (j > 0) begin
                @(posedge clk);
                #1;
            end
            if (bus.busy && bus.done) overlap++;
            if (bus.done) begin
                checkOutput("held donePos", 32'(j), 32'(k * (N + 1) + N));
                checkOutput("held sum",  32'(bus.sum),  32'h0000);
                checkOutput("held cout", 32'(bus.cout), 32'd1);
                k++;
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("held results", 32'(k), 32'd3);
        checkOutput("held overlap", 32'(overlap), 32'd0);
        repeat (N + 2) @(posedge clk);
        #1;
        checkOutput("held drained busy", 32'(bus.busy), 32'd0);

        // Start during RUN with different operands is ignored, and bus
        // operand changes after acceptance have no effect.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h1234;
        bus.b     = 16'h4321;
        bus.cin   = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        bus.a   = 16'hFFFF;
        bus.b   = 16'hFFFF;
        bus.cin = 1'b1;
        doneCnt = 0;
        for (int j = 1; j <= N + 3; j++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                doneCnt++;
                checkOutput("ignore donePos", 32'(j), 32'(N));
                checkOutput("ignore sum",  32'(bus.sum),  32'h5555);
                checkOutput("ignore cout", 32'(bus.cout), 32'd0);
            end
            if (j == N - 1) begin
                @(negedge clk);
                bus.start = 1'b0;
            end
        end
        checkOutput("ignore donePulses", 32'(doneCnt), 32'd1);
        checkOutput("ignore idle busy",  32'(bus.busy), 32'd0);
        checkOutput("ignore sum held",   32'(bus.sum),  32'h5555);

        // Asynchronous reset while nibble 2 is being processed.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h00AA;
        bus.b     = 16'h0011;
        bus.cin   = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checkOutput("midRst sum hold", 32'(bus.sum), 32'h5555);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("midRst busy", 32'(bus.busy), 32'd0);
        checkOutput("midRst done", 32'(bus.done), 32'd0);
        checkOutput("midRst sum",  32'(bus.sum),  32'd0);
        checkOutput("midRst cout", 32'(bus.cout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        doneCnt = 0;
        for (int j = 0; j < N + 3; j++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) doneCnt++;
        end
        checkOutput("midRst quiet", 32'(doneCnt), 32'd0);
        applyStimulus("afterRst", 16'h0003, 16'h0005, 1'b0, 16'h0008, 1'b0);

        // Random sweep against integer addition.
        for (int i = 0; i < 1000; i++) begin
            ra    = 16'($urandom);
            rb    = 16'($urandom);
            rc    = 1'($urandom);
            total = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
            applyStimulus("rand", ra, rb, rc, total[15:0], total[16]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

    // Hard time limit so a stuck design still ends the run.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout: got no finish, expected finish before limit");
        $fatal(1, "[TB] timeout");
    end

endmodule
